// File: rtl/dsi_packet_assembler_pkg.sv
// rtl/dsi_packet_assembler_pkg.sv - shared DSI packet types, constants and ECC helper
package dsi_packet_assembler_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAYLOAD,
        S_CRC,
        S_DONE
    } state_t;

    localparam logic [5:0] PTYPE_VSYNC_START = 6'h01;
    localparam logic [5:0] PTYPE_VSYNC_END   = 6'h11;
    localparam logic [5:0] PTYPE_HSYNC_START = 6'h21;
    localparam logic [5:0] PTYPE_HSYNC_END   = 6'h31;
    localparam logic [5:0] PTYPE_BLANKING    = 6'h19;
    localparam logic [5:0] PTYPE_DCS_LONG    = 6'h39;
    localparam logic [5:0] PTYPE_RGB888      = 6'h3E;

    localparam logic [15:0] DSI_CRC_INIT      = 16'hFFFF;
    localparam logic [15:0] DSI_CRC_POLY_REFL = 16'h8408;

    // DSI header ECC: 6 parity bits over {b2, b1, DI}; bits [7:6] are always 0.
    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [7:0] e;
        e    = 8'h00;
        e[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        e[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        e[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        e[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        e[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        e[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return e;
    endfunction

endpackage

// File: rtl/dsi_packet_assembler_if.sv
// rtl/dsi_packet_assembler_if.sv - packet request and HS byte stream bundle
interface dsi_packet_assembler_if #(
    parameter int G = 1
);
    logic              p_req;
    logic              p_islong;
    logic [5:0]        p_type;
    logic [15:0]       p_wcount;
    logic [15:0]       p_command;
    logic              p_last;
    logic [24*G-1:0]   p_payload;
    logic              p_dreq;
    logic [7:0]        hs_data;
    logic              hs_valid;
    logic              hs_sop;
    logic              hs_eot;

    modport slave (
        input  p_req, p_islong, p_type, p_wcount, p_command, p_last, p_payload,
        output p_dreq, hs_data, hs_valid, hs_sop, hs_eot
    );

    modport master (
        output p_req, p_islong, p_type, p_wcount, p_command, p_last, p_payload,
        input  p_dreq, hs_data, hs_valid, hs_sop, hs_eot
    );
endinterface

// File: rtl/dsi_packet_assembler_crc16.sv
// rtl/dsi_packet_assembler_crc16.sv - byte-wide reflected CRC-16 accumulator
module dsi_crc16
    import dsi_packet_assembler_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    // One byte folded in LSB-first through the reflected polynomial.
    function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ DSI_CRC_POLY_REFL) : (r >> 1);
        end
        return r;
    endfunction

    // Next CRC: init wins over an update in the same cycle.
    always_comb begin
        crc_d = crc_q;
        if (init_i) begin
            crc_d = DSI_CRC_INIT;
        end else if (en_i) begin
            crc_d = crc_byte(crc_q, data_i);
        end
    end

    // CRC register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            crc_q <= DSI_CRC_INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/dsi_packet_assembler.sv
// rtl/dsi_packet_assembler.sv - serializes DSI packet requests into a gapless HS byte stream
module dsi_packet_assembler
    import dsi_packet_assembler_pkg::*;
#(
    parameter int g_pixels_per_clock = 1,
    parameter int g_virtual_channel  = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    dsi_packet_assembler_if.slave   pif,
    output logic                    busy_o
);

    localparam int         W        = 3 * g_pixels_per_clock;
    localparam int         PW       = 24 * g_pixels_per_clock;
    localparam logic [1:0] VC       = 2'(g_virtual_channel);
    localparam logic [7:0] POS_LAST = 8'(W - 1);
    localparam logic [7:0] POS_REQ  = 8'(W - 3);

    state_t          state_q;
    logic [1:0]      hcnt_q;
    logic            ccnt_q;
    logic [7:0]      pos_q;
    logic [15:0]     rem_q;
    logic            islong_q;
    logic            last_q;
    logic [5:0]      type_q;
    logic [7:0]      b1_q;
    logic [7:0]      b2_q;
    logic [15:0]     wc_q;
    logic [PW-1:0]   word_q;
    logic [7:0]      data_q;
    logic            valid_q;
    logic            sop_q;
    logic            eot_q;
    logic            dreq_q;

    logic [7:0]      ecc_d;
    logic [7:0]      word_byte_d;
    logic [7:0]      pay_byte_d;
    logic            crc_en_d;
    logic            crc_init_d;
    logic [15:0]     crc;
    logic            accept_d;

    assign accept_d   = (state_q == S_IDLE) && pif.p_req;
    assign crc_init_d = accept_d;
    assign ecc_d      = dsi_ecc({b2_q, b1_q, VC, type_q});

    // Byte following the one on the output, taken from the held word.
    always_comb begin
        word_byte_d = 8'h00;
        for (int i = 0; i < W; i++) begin
            if (pos_q + 8'd1 == 8'(i)) begin
                word_byte_d = word_q[8*i +: 8];
            end
        end
    end

    // Payload byte loaded this cycle; a fresh word is taken straight from the FIFO port.
    always_comb begin
        crc_en_d   = 1'b0;
        pay_byte_d = 8'h00;
        if (state_q == S_HDR && hcnt_q == 2'd3 && islong_q && wc_q != 16'd0) begin
            crc_en_d   = 1'b1;
            pay_byte_d = pif.p_payload[7:0];
        end else if (state_q == S_PAYLOAD && rem_q != 16'd0) begin
            crc_en_d   = 1'b1;
            pay_byte_d = (pos_q == POS_LAST) ? pif.p_payload[7:0] : word_byte_d;
        end
    end

    dsi_crc16 u_crc (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .init_i  (crc_init_d),
        .en_i    (crc_en_d),
        .data_i  (pay_byte_d),
        .crc_o   (crc)
    );

    // Packet FSM; the output registers always hold the byte of the current state.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            hcnt_q   <= 2'd0;
            ccnt_q   <= 1'b0;
            pos_q    <= 8'd0;
            rem_q    <= 16'd0;
            islong_q <= 1'b0;
            last_q   <= 1'b0;
            type_q   <= 6'd0;
            b1_q     <= 8'd0;
            b2_q     <= 8'd0;
            wc_q     <= 16'd0;
            word_q   <= '0;
            data_q   <= 8'd0;
            valid_q  <= 1'b0;
            sop_q    <= 1'b0;
            eot_q    <= 1'b0;
            dreq_q   <= 1'b0;
        end else begin
            sop_q  <= 1'b0;
            eot_q  <= 1'b0;
            dreq_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    valid_q <= 1'b0;
                    data_q  <= 8'd0;
                    if (pif.p_req) begin
                        islong_q <= pif.p_islong;
                        last_q   <= pif.p_last;
                        type_q   <= pif.p_type;
                        wc_q     <= pif.p_wcount;
                        b1_q     <= pif.p_islong ? pif.p_wcount[7:0]  : pif.p_command[7:0];
                        b2_q     <= pif.p_islong ? pif.p_wcount[15:8] : pif.p_command[15:8];
                        data_q   <= {VC, pif.p_type};
                        valid_q  <= 1'b1;
                        sop_q    <= 1'b1;
                        hcnt_q   <= 2'd0;
                        state_q  <= S_HDR;
                    end
                end
                S_HDR: begin
                    case (hcnt_q)
                        2'd0: begin
                            data_q <= b1_q;
                            hcnt_q <= 2'd1;
                        end
                        2'd1: begin
                            data_q <= b2_q;
                            hcnt_q <= 2'd2;
                            // First word request lands two bytes ahead of payload byte 0.
                            dreq_q <= islong_q && (wc_q != 16'd0);
                        end
                        2'd2: begin
                            data_q <= ecc_d;
                            hcnt_q <= 2'd3;
                        end
                        default: begin
                            if (islong_q && wc_q != 16'd0) begin
                                data_q  <= pay_byte_d;
                                word_q  <= pif.p_payload;
                                pos_q   <= 8'd0;
                                rem_q   <= wc_q - 16'd1;
                                state_q <= S_PAYLOAD;
                            end else if (islong_q) begin
                                data_q  <= crc[7:0];
                                ccnt_q  <= 1'b0;
                                state_q <= S_CRC;
                            end else begin
                                data_q  <= 8'd0;
                                valid_q <= 1'b0;
                                eot_q   <= last_q;
                                state_q <= S_DONE;
                            end
                        end
                    endcase
                end
                S_PAYLOAD: begin
                    if (rem_q == 16'd0) begin
                        data_q  <= crc[7:0];
                        ccnt_q  <= 1'b0;
                        state_q <= S_CRC;
                    end else begin
                        data_q <= pay_byte_d;
                        rem_q  <= rem_q - 16'd1;
                        if (pos_q == POS_LAST) begin
                            word_q <= pif.p_payload;
                            pos_q  <= 8'd0;
                        end else begin
                            pos_q <= pos_q + 8'd1;
                        end
                        // Request the next word only if bytes remain beyond the current one.
                        dreq_q <= (pos_q == POS_REQ) && (rem_q >= 16'd3);
                    end
                end
                S_CRC: begin
                    if (!ccnt_q) begin
                        data_q <= crc[15:8];
                        ccnt_q <= 1'b1;
                    end else begin
                        data_q  <= 8'd0;
                        valid_q <= 1'b0;
                        eot_q   <= last_q;
                        state_q <= S_DONE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign pif.p_dreq   = rst_n_i && (accept_d || dreq_q);
    assign pif.hs_data  = data_q;
    assign pif.hs_valid = valid_q;
    assign pif.hs_sop   = sop_q;
    assign pif.hs_eot   = eot_q;
    assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_dsi_packet_assembler.sv
// tb/tb_dsi_packet_assembler.sv - self-checking bench for dsi_packet_assembler
module tb_dsi_packet_assembler;
    import dsi_packet_assembler_pkg::*;

    localparam int         G  = 1;
    localparam int         W  = 3 * G;
    localparam logic [1:0] VC = 2'd0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic [23:0] word_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          got_cyc[$];
    int          sop_cyc[$];
    int          eot_cyc[$];
    int          dreq_cyc[$];
    int          busy_low_cyc = -1;
    logic        busy_prev = 1'b0;
    logic        timeout;

    dsi_packet_assembler_if #(.G(G)) pif ();

    dsi_packet_assembler #(
        .g_pixels_per_clock (G),
        .g_virtual_channel  (0)
    ) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .pif     (pif.slave),
        .busy_o  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (pif.hs_valid) begin
            got_q.push_back(pif.hs_data);
            got_cyc.push_back(cyc);
        end
        if (pif.hs_sop) sop_cyc.push_back(cyc);
        if (pif.hs_eot) eot_cyc.push_back(cyc);
        if (busy_prev && !busy) busy_low_cyc = cyc;
        busy_prev = busy;
    end

    // Pixel FIFO stand-in: a word appears for exactly one cycle after each request, garbage otherwise.
    always begin : feeder
        logic pl;
        @(negedge clk);
        pl = pif.p_dreq && busy;
        if (pl) dreq_cyc.push_back(cyc);
        @(posedge clk);
        #1;
        if (pl && word_q.size() > 0) pif.p_payload = word_q.pop_front();
        else pif.p_payload = 24'($urandom);
    end

    task automatic clear_capture();
        got_q.delete(); got_cyc.delete(); sop_cyc.delete();
        eot_cyc.delete(); dreq_cyc.delete(); busy_low_cyc = -1;
    endtask

    // Expected byte stream for one packet; payload comes from word_q starting at word woff.
    task automatic build_exp(input logic il, input logic [5:0] ty, input logic [15:0] wc,
                             input logic [15:0] cmd, input int woff);
        logic [23:0] mk[6];
        logic [23:0] hdr;
        logic [23:0] w;
        logic [7:0]  ecc;
        logic [7:0]  b;
        logic [15:0] crc;
        mk[0] = 24'hF12CB7; mk[1] = 24'hF2555B; mk[2] = 24'h749A6D;
        mk[3] = 24'hB8E38E; mk[4] = 24'hDF03F0; mk[5] = 24'hEFFC00;
        hdr = il ? {wc, VC, ty} : {cmd, VC, ty};
        ecc = 8'h00;
        for (int p = 0; p < 6; p++) ecc[p] = ^(hdr & mk[p]);
        exp_q.push_back(hdr[7:0]);
        exp_q.push_back(hdr[15:8]);
        exp_q.push_back(hdr[23:16]);
        exp_q.push_back(ecc);
        if (il) begin
            crc = 16'hFFFF;
            for (int k = 0; k < int'(wc); k++) begin
                w = word_q[woff + k / W];
                b = 8'(w >> (8 * (k % W)));
                exp_q.push_back(b);
                crc = crc ^ {8'h00, b};
                for (int j = 0; j < 8; j++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
            end
            exp_q.push_back(crc[7:0]);
            exp_q.push_back(crc[15:8]);
        end
    endtask

    task automatic drive_fields(input logic il, input logic [5:0] ty, input logic [15:0] wc,
                                input logic [15:0] cmd, input logic lst);
        pif.p_islong = il; pif.p_type = ty; pif.p_wcount = wc;
        pif.p_command = cmd; pif.p_last = lst;
    endtask

    task automatic scramble_fields();
        drive_fields(1'($urandom), 6'($urandom), 16'($urandom), 16'($urandom), 1'($urandom));
    endtask

    // Issue one request, release it after the accept edge, wait for the packet to finish.
    task automatic send_packet(input logic il, input logic [5:0] ty, input logic [15:0] wc,
                               input logic [15:0] cmd, input logic lst);
        logic acc;
        logic done;
        clear_capture();
        exp_q.delete();
        build_exp(il, ty, wc, cmd, 0);
        @(posedge clk); #1;
        drive_fields(il, ty, wc, cmd, lst);
        pif.p_req = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 8 && !acc; i++) begin
            @(negedge clk);
            if (pif.p_dreq && !busy) acc = 1'b1;
        end
        @(posedge clk); #1;
        pif.p_req = 1'b0;
        scramble_fields();
        done = 1'b0;
        for (int i = 0; i < int'(wc) + 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        timeout = !(acc && done);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        pif.p_req = 1'b0;
        scramble_fields();
        repeat (3) @(negedge clk);
        checks++;
        if ({pif.hs_valid, pif.hs_sop, pif.hs_eot, pif.p_dreq, busy, pif.hs_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {pif.hs_valid, pif.hs_sop, pif.hs_eot, pif.p_dreq, busy, pif.hs_data});
        end
        @(posedge clk); #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({pif.hs_valid, pif.p_dreq, busy} !== 3'd0) begin
            errors++;
            $display("FAIL idle_after_reset got %b want 000", {pif.hs_valid, pif.p_dreq, busy});
        end
    endtask

    task automatic test_short_vsync();
        logic [7:0] want[4];
        want[0] = 8'h01; want[1] = 8'h00; want[2] = 8'h00; want[3] = 8'h07;
        send_packet(1'b0, PTYPE_VSYNC_START, 16'h1234, 16'h0000, 1'b0);
        checks++;
        if (timeout || got_q.size() != 4) begin
            errors++;
            $display("FAIL vsync_len got %0d want 4 (timeout %0d)", got_q.size(), timeout);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== want[i]) begin
                    errors++;
                    $display("FAIL vsync_byte%0d got %h want %h", i, got_q[i], want[i]);
                end
            end
            checks++;
            if (sop_cyc.size() != 1 || sop_cyc[0] != got_cyc[0]) begin
                errors++;
                $display("FAIL vsync_sop got count %0d want 1 on DI", sop_cyc.size());
            end
        end
        checks++;
        if (eot_cyc.size() != 0) begin
            errors++;
            $display("FAIL vsync_eot got %0d pulses want 0", eot_cyc.size());
        end
    endtask

    task automatic test_long_crc();
        word_q.delete();
        word_q.push_back(24'h333231); word_q.push_back(24'h363534); word_q.push_back(24'h393837);
        send_packet(1'b1, PTYPE_DCS_LONG, 16'd9, 16'hBEEF, 1'b0);
        checks++;
        if (timeout || got_q.size() != 15) begin
            errors++;
            $display("FAIL long9_len got %0d want 15 (timeout %0d)", got_q.size(), timeout);
        end else begin
            for (int i = 0; i < 9; i++) begin
                checks++;
                if (got_q[4 + i] !== 8'(8'h31 + i)) begin
                    errors++;
                    $display("FAIL long9_payload%0d got %h want %h", i, got_q[4 + i], 8'(8'h31 + i));
                end
            end
            checks++;
            if ({got_q[14], got_q[13]} !== 16'h6F91) begin
                errors++;
                $display("FAIL long9_crc got %h%h want 6f91", got_q[14], got_q[13]);
            end
            checks++;
            if (got_q[3] !== exp_q[3]) begin
                errors++;
                $display("FAIL long9_ecc got %h want %h", got_q[3], exp_q[3]);
            end
            checks++;
            if (got_cyc[14] - got_cyc[0] != 14) begin
                errors++;
                $display("FAIL long9_gapless got span %0d want 14", got_cyc[14] - got_cyc[0]);
            end
            checks++;
            if (dreq_cyc.size() != 3 || dreq_cyc[0] != got_cyc[0] + 2 ||
                dreq_cyc[1] - dreq_cyc[0] != W || dreq_cyc[2] - dreq_cyc[1] != W) begin
                errors++;
                $display("FAIL long9_dreq got %0d pulses, first at DI+%0d want 3 at DI+2 spaced %0d",
                         dreq_cyc.size(), dreq_cyc.size() > 0 ? dreq_cyc[0] - got_cyc[0] : -1, W);
            end
        end
    endtask

    task automatic test_blanking_partial();
        word_q.delete();
        repeat (3) word_q.push_back(24'h000000);
        send_packet(1'b1, PTYPE_BLANKING, 16'd8, 16'h0000, 1'b0);
        checks++;
        if (timeout || got_q.size() != 14 || dreq_cyc.size() != 3) begin
            errors++;
            $display("FAIL blank8_shape got len %0d dreq %0d want len 14 dreq 3",
                     got_q.size(), dreq_cyc.size());
        end else begin
            checks++;
            if (got_q != exp_q) begin
                errors++;
                $display("FAIL blank8_stream got crc %h%h want %h%h",
                         got_q[13], got_q[12], exp_q[13], exp_q[12]);
            end
        end
        checks++;
        if (word_q.size() != 0) begin
            errors++;
            $display("FAIL blank8_words_left got %0d want 0", word_q.size());
        end
    endtask

    task automatic test_wc0();
        word_q.delete();
        send_packet(1'b1, PTYPE_RGB888, 16'd0, 16'h5555, 1'b0);
        checks++;
        if (timeout || got_q.size() != 6) begin
            errors++;
            $display("FAIL wc0_len got %0d want 6", got_q.size());
        end else begin
            checks++;
            if ({got_q[4], got_q[5]} !== 16'hFFFF || got_q[1] !== 8'h00 || got_q[2] !== 8'h00) begin
                errors++;
                $display("FAIL wc0_bytes got wc %h%h crc %h%h want 0000 ffff",
                         got_q[2], got_q[1], got_q[5], got_q[4]);
            end
        end
        checks++;
        if (dreq_cyc.size() != 0) begin
            errors++;
            $display("FAIL wc0_dreq got %0d pulses want 0", dreq_cyc.size());
        end
    endtask

    task automatic test_hsync_last();
        send_packet(1'b0, PTYPE_HSYNC_START, 16'hAAAA, 16'h0000, 1'b1);
        checks++;
        if (timeout || got_q.size() != 4 || got_q[0] !== 8'h21 || got_q[3] !== 8'h12) begin
            errors++;
            $display("FAIL hsync_bytes got len %0d want 21 00 00 12", got_q.size());
        end else begin
            checks++;
            if (eot_cyc.size() != 1 || eot_cyc[0] != got_cyc[3] + 1) begin
                errors++;
                $display("FAIL hsync_eot got %0d pulses want 1 right after ECC", eot_cyc.size());
            end else begin
                checks++;
                if (busy_low_cyc != eot_cyc[0] + 1) begin
                    errors++;
                    $display("FAIL hsync_busy_low got cycle %0d want %0d", busy_low_cyc, eot_cyc[0] + 1);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] cmd;
        word_q.delete();
        for (int i = 0; i < 10; i++) word_q.push_back(24'($urandom));
        @(posedge clk); #1;
        drive_fields(1'b1, PTYPE_RGB888, 16'd30, 16'h0, 1'b1);
        pif.p_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        pif.p_req = 1'b0;
        repeat (9) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pif.hs_valid, pif.hs_sop, pif.hs_eot, pif.p_dreq, busy, pif.hs_data} !== 13'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs got %h want 0",
                     {pif.hs_valid, pif.hs_sop, pif.hs_eot, pif.p_dreq, busy, pif.hs_data});
        end
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        word_q.delete();
        cmd = 16'($urandom);
        send_packet(1'b0, PTYPE_VSYNC_END, 16'h0, cmd, 1'b0);
        checks++;
        if (timeout || got_q != exp_q) begin
            errors++;
            $display("FAIL reset_mid_short got len %0d want %0d", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < 2; i++) word_q.push_back(24'($urandom));
        send_packet(1'b1, PTYPE_RGB888, 16'd5, 16'h0, 1'b0);
        checks++;
        if (timeout || got_q != exp_q) begin
            errors++;
            $display("FAIL reset_mid_long got len %0d want %0d", got_q.size(), exp_q.size());
        end
    endtask

    task automatic test_random();
        logic        il, lst;
        logic [5:0]  ty;
        logic [15:0] wc, cmd;
        int          nw, n;
        for (int t = 0; t < 10; t++) begin
            il  = 1'($urandom);
            ty  = 6'($urandom);
            cmd = 16'($urandom);
            lst = 1'($urandom);
            wc  = il ? 16'($urandom_range(0, 40)) : 16'($urandom);
            nw  = il ? (int'(wc) + W - 1) / W : 0;
            word_q.delete();
            for (int i = 0; i < nw; i++) word_q.push_back(24'($urandom));
            send_packet(il, ty, wc, cmd, lst);
            n = got_q.size();
            checks++;
            if (timeout || got_q != exp_q) begin
                errors++;
                $display("FAIL rand%0d_stream long %0d wc %0d got len %0d want %0d",
                         t, il, wc, n, exp_q.size());
            end
            checks++;
            if (n == 0 || got_cyc[n - 1] - got_cyc[0] != n - 1 ||
                sop_cyc.size() != 1 || sop_cyc[0] != got_cyc[0]) begin
                errors++;
                $display("FAIL rand%0d_framing got len %0d sops %0d want gapless with 1 sop",
                         t, n, sop_cyc.size());
            end
            checks++;
            if (dreq_cyc.size() != nw) begin
                errors++;
                $display("FAIL rand%0d_dreq_count got %0d want %0d", t, dreq_cyc.size(), nw);
            end else if (nw > 0 && n > 0) begin
                for (int i = 0; i < nw; i++) begin
                    checks++;
                    if (dreq_cyc[i] != got_cyc[0] + 2 + i * W) begin
                        errors++;
                        $display("FAIL rand%0d_dreq%0d got DI+%0d want DI+%0d",
                                 t, i, dreq_cyc[i] - got_cyc[0], 2 + i * W);
                    end
                end
            end
            checks++;
            if (eot_cyc.size() != int'(lst)) begin
                errors++;
                $display("FAIL rand%0d_eot got %0d want %0d", t, eot_cyc.size(), lst);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        acc;
        logic        done;
        logic [15:0] cmd_b;
        word_q.delete();
        for (int i = 0; i < 2; i++) word_q.push_back(24'($urandom));
        cmd_b = 16'($urandom);
        clear_capture();
        exp_q.delete();
        build_exp(1'b1, PTYPE_RGB888, 16'd5, 16'h0, 0);
        build_exp(1'b0, PTYPE_HSYNC_END, 16'h0, cmd_b, 2);
        @(posedge clk); #1;
        drive_fields(1'b1, PTYPE_RGB888, 16'd5, 16'h0, 1'b0);
        pif.p_req = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        drive_fields(1'b0, PTYPE_HSYNC_END, 16'h0, cmd_b, 1'b1);
        acc = 1'b0;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (pif.p_dreq && !busy) acc = 1'b1;
        end
        @(posedge clk); #1;
        pif.p_req = 1'b0;
        scramble_fields();
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!busy) done = 1'b1;
        end
        repeat (2) @(negedge clk);
        checks++;
        if (!acc || !done || got_q != exp_q) begin
            errors++;
            $display("FAIL b2b_stream got len %0d want %0d (acc %0d done %0d)",
                     got_q.size(), exp_q.size(), acc, done);
        end
        checks++;
        if (sop_cyc.size() != 2 || eot_cyc.size() != 1) begin
            errors++;
            $display("FAIL b2b_flags got sop %0d eot %0d want 2 and 1", sop_cyc.size(), eot_cyc.size());
        end
    endtask

    initial begin
        pif.p_req     = 1'b0;
        pif.p_payload = 24'h0;
        drive_fields(1'b0, 6'd0, 16'd0, 16'd0, 1'b0);
        test_reset();
        test_short_vsync();
        test_long_crc();
        test_blanking_partial();
        test_wc0();
        test_hsync_last();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
